// File: rtl/control_sequencer_pkg.sv
// Shared sequencer types: ns_sel encodings, microstate type, default entry states.
// No logic; constants only. No backpressure.
package control_sequencer_pkg;

  typedef logic [7:0] ustate_t;

  typedef enum logic [2:0] {
    NS_DISPATCH = 3'd0,
    NS_INCR     = 3'd1,
    NS_BRANCH   = 3'd2,
    NS_COND     = 3'd3,
    NS_WAIT_MFC = 3'd4,
    NS_RETURN   = 3'd5,
    NS_CALL     = 3'd6,
    NS_RESTART  = 3'd7
  } ns_sel_e;

  localparam ustate_t DEF_RESET_STATE = 8'd0;
  localparam ustate_t DEF_ABORT_STATE = 8'd255;

endpackage

// File: rtl/control_sequencer_mfc_wait_timer.sv
// Counts consecutive unstalled wait-MFC cycles; flags timeout once MFC_TIMEOUT have elapsed.
// timeout is combinational on the current count. stall freezes the count.
module mfc_wait_timer #(
  parameter int MFC_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic stall,
  input  logic waiting,
  input  logic mfc,
  output logic timeout
);

  localparam int CW = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MFC_TIMEOUT);

  logic [CW-1:0] cnt;

  // mfc arriving on the limit edge wins over the abort
  assign timeout = waiting && !mfc && (cnt == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!stall) begin
      if (!waiting || mfc || timeout) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcode next-address sequencer with one-level call/return; MFC timeout under CTRL_SEQ_MFC_TIMEOUT_EN.
// One clock from ns_sel to state; dispatch/mfc_abort pulse the cycle after. stall freezes everything.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter ustate_t RESET_STATE = DEF_RESET_STATE,
  parameter ustate_t ABORT_STATE = DEF_ABORT_STATE,
  parameter int      MFC_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] enc_state,
  input  logic [2:0] ns_sel,
  input  logic [7:0] cr_addr,
  input  logic       cond_true,
  input  logic       inv,
  input  logic       mfc,
  input  logic       stall,
  output logic [7:0] state,
  output logic       dispatch,
  output logic       mfc_abort
);

  ustate_t ret_reg;
  logic    ret_valid;
  ustate_t nxt_state;
  ustate_t nxt_ret;
  logic    nxt_ret_valid;
  logic    nxt_dispatch;
  logic    nxt_abort;
  logic    mfc_timeout;
  ustate_t state_inc;

  assign state_inc = state + 8'd1;

`ifdef CTRL_SEQ_MFC_TIMEOUT_EN
  mfc_wait_timer #(
    .MFC_TIMEOUT (MFC_TIMEOUT)
  ) u_mfc_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .stall   (stall),
    .waiting (ns_sel == NS_WAIT_MFC),
    .mfc     (mfc),
    .timeout (mfc_timeout)
  );
`else
  assign mfc_timeout = 1'b0;
  logic unused_cfg;
  assign unused_cfg = &{1'b0, MFC_TIMEOUT[0]};
`endif

  always_comb begin
    nxt_state     = state;
    nxt_ret       = ret_reg;
    nxt_ret_valid = ret_valid;
    nxt_dispatch  = 1'b0;
    nxt_abort     = 1'b0;
    if (!stall) begin
      case (ns_sel_e'(ns_sel))
        NS_DISPATCH: begin
          nxt_state    = enc_state;
          nxt_dispatch = 1'b1;
        end
        NS_INCR:   nxt_state = state_inc;
        NS_BRANCH: nxt_state = cr_addr;
        NS_COND:   nxt_state = (cond_true ^ inv) ? cr_addr : state_inc;
        NS_WAIT_MFC: begin
          if (mfc) begin
            nxt_state = state_inc;
          end else if (mfc_timeout) begin
            nxt_state = ABORT_STATE;
            nxt_abort = 1'b1;
          end
        end
        NS_RETURN: begin
          // a return with nothing saved falls back to fetch
          nxt_state     = ret_valid ? ret_reg : RESET_STATE;
          nxt_ret_valid = 1'b0;
        end
        NS_CALL: begin
          nxt_ret       = state_inc;
          nxt_ret_valid = 1'b1;
          nxt_state     = cr_addr;
        end
        NS_RESTART: nxt_state = RESET_STATE;
        default:    nxt_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_STATE;
      ret_reg   <= '0;
      ret_valid <= 1'b0;
      dispatch  <= 1'b0;
      mfc_abort <= 1'b0;
    end else begin
      state     <= nxt_state;
      ret_reg   <= nxt_ret;
      ret_valid <= nxt_ret_valid;
      dispatch  <= nxt_dispatch;
      mfc_abort <= nxt_abort;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected outputs queued at drive time, checked after each edge.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] enc_state;
  logic [2:0] ns_sel;
  logic [7:0] cr_addr;
  logic       cond_true;
  logic       inv;
  logic       mfc;
  logic       stall;
  logic [7:0] state;
  logic       dispatch;
  logic       mfc_abort;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] st;
    logic       d;
    logic       a;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enc_state (enc_state),
    .ns_sel    (ns_sel),
    .cr_addr   (cr_addr),
    .cond_true (cond_true),
    .inv       (inv),
    .mfc       (mfc),
    .stall     (stall),
    .state     (state),
    .dispatch  (dispatch),
    .mfc_abort (mfc_abort)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // inputs must already be set; pushes the expectation, clocks once, checks
  task automatic tick(input string tag, input logic [7:0] es, input logic ed, input logic ea);
    exp_t e;
    exp_t g;
    e.st = es;
    e.d  = ed;
    e.a  = ea;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    chk({tag, ".state"}, state, g.st);
    chk({tag, ".dispatch"}, {7'd0, dispatch}, {7'd0, g.d});
    chk({tag, ".abort"}, {7'd0, mfc_abort}, {7'd0, g.a});
    @(negedge clk);
  endtask

  task automatic set(input logic [2:0] ns, input logic [7:0] enc, input logic [7:0] cr);
    ns_sel    = ns;
    enc_state = enc;
    cr_addr   = cr;
  endtask

  initial begin
    reset_n = 1'b0; enc_state = 8'd0; ns_sel = 3'd1; cr_addr = 8'd0;
    cond_true = 1'b0; inv = 1'b0; mfc = 1'b0; stall = 1'b0;
    #12;
    chk("reset.state", state, 8'd0);
    chk("reset.dispatch", {7'd0, dispatch}, 8'd0);
    chk("reset.abort", {7'd0, mfc_abort}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // dispatch, one-cycle pulse
    set(3'd0, 8'd16, 8'd0); tick("disp16", 8'd16, 1'b1, 1'b0);
    set(3'd1, 8'd0, 8'd0);  tick("inc17", 8'd17, 1'b0, 1'b0);

    // conditional branch with inversion
    set(3'd0, 8'd10, 8'd0); tick("disp10a", 8'd10, 1'b1, 1'b0);
    set(3'd3, 8'd0, 8'd40); cond_true = 1'b1; inv = 1'b1;
    tick("cond_inv", 8'd11, 1'b0, 1'b0);
    set(3'd0, 8'd10, 8'd0); tick("disp10b", 8'd10, 1'b1, 1'b0);
    set(3'd3, 8'd0, 8'd40); inv = 1'b0;
    tick("cond_taken", 8'd40, 1'b0, 1'b0);
    cond_true = 1'b0;
    tick("cond_fall", 8'd41, 1'b0, 1'b0);
    set(3'd2, 8'd0, 8'd77); tick("branch", 8'd77, 1'b0, 1'b0);

    // call / return / empty return
    set(3'd0, 8'd20, 8'd0);  tick("disp20", 8'd20, 1'b1, 1'b0);
    set(3'd6, 8'd0, 8'd100); tick("call100", 8'd100, 1'b0, 1'b0);
    set(3'd5, 8'd0, 8'd0);   tick("ret21", 8'd21, 1'b0, 1'b0);
    tick("ret_empty", 8'd0, 1'b0, 1'b0);

    // second call overwrites the single return slot
    set(3'd6, 8'd0, 8'd50); tick("call50", 8'd50, 1'b0, 1'b0);
    set(3'd6, 8'd0, 8'd60); tick("call60", 8'd60, 1'b0, 1'b0);
    set(3'd5, 8'd0, 8'd0);  tick("ret51", 8'd51, 1'b0, 1'b0);
    set(3'd7, 8'd0, 8'd0);  tick("restart", 8'd0, 1'b0, 1'b0);

    // wraparound, then stall holding state and return context
    set(3'd0, 8'd255, 8'd0); tick("disp255", 8'd255, 1'b1, 1'b0);
    set(3'd1, 8'd0, 8'd0);   tick("wrap", 8'd0, 1'b0, 1'b0);
    set(3'd6, 8'd0, 8'd70);  tick("call70", 8'd70, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set(3'(i), 8'd7, 8'd9);
      tick("stall", 8'd70, 1'b0, 1'b0);
    end
    stall = 1'b0;
    set(3'd5, 8'd0, 8'd0); tick("ret_after_stall", 8'd1, 1'b0, 1'b0);

    // MFC wait with no completion
    set(3'd0, 8'd30, 8'd0); tick("disp30a", 8'd30, 1'b1, 1'b0);
    set(3'd4, 8'd0, 8'd0);  mfc = 1'b0;
`ifdef CTRL_SEQ_MFC_TIMEOUT_EN
    for (int i = 0; i < 16; i++) tick("wait_hold", 8'd30, 1'b0, 1'b0);
    tick("timeout", 8'd255, 1'b0, 1'b1);
    set(3'd1, 8'd0, 8'd0);  tick("post_abort", 8'd0, 1'b0, 1'b0);
`else
    for (int i = 0; i < 24; i++) tick("wait_hold", 8'd30, 1'b0, 1'b0);
    set(3'd1, 8'd0, 8'd0);  tick("post_wait", 8'd31, 1'b0, 1'b0);
`endif

    // MFC arrives on the third wait cycle
    set(3'd0, 8'd30, 8'd0); tick("disp30b", 8'd30, 1'b1, 1'b0);
    set(3'd4, 8'd0, 8'd0);
    tick("wait1", 8'd30, 1'b0, 1'b0);
    tick("wait2", 8'd30, 1'b0, 1'b0);
    mfc = 1'b1;
    tick("mfc_done", 8'd31, 1'b0, 1'b0);
    mfc = 1'b0;

    // async reset mid-call, mid-wait
    set(3'd0, 8'd20, 8'd0); tick("disp20b", 8'd20, 1'b1, 1'b0);
    set(3'd6, 8'd0, 8'd80); tick("call80", 8'd80, 1'b0, 1'b0);
    set(3'd4, 8'd0, 8'd0);
    tick("wait80a", 8'd80, 1'b0, 1'b0);
    tick("wait80b", 8'd80, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.state", state, 8'd0);
    chk("async_rst.dispatch", {7'd0, dispatch}, 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    set(3'd2, 8'd0, 8'd50); tick("post_rst_branch", 8'd50, 1'b0, 1'b0);
    set(3'd5, 8'd0, 8'd0);  tick("post_rst_ret", 8'd0, 1'b0, 1'b0);

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
